// File: rtl/data_cache_l0_assoc.sv
// rtl/data_cache_l0_assoc.sv - fully-associative write-back/write-allocate L0 data cache
// Miss FSM with mem req/gnt handshake, invalid-first + round-robin victim, full flush, saturating counters.
module data_cache_l0_assoc #(
  parameter int ADDR_WIDTH         = 32,
  parameter int LOG2_WORDS_IN_LINE = 2,
  parameter int LOG2_NUM_LINES     = 3,
  parameter int CNT_WIDTH          = 16,
  localparam int LINE_W            = 32 * (2 ** LOG2_WORDS_IN_LINE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic [3:0]            core_be_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [31:0]           core_wdata_i,
  output logic                  core_gnt_o,
  output logic                  core_rvalid_o,
  output logic [31:0]           core_rdata_o,
  input  logic                  flush_i,
  output logic                  flush_done_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [LINE_W/8-1:0]   mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [LINE_W-1:0]     mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [LINE_W-1:0]     mem_rdata_i,
  output logic [CNT_WIDTH-1:0]  hit_cnt_o,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o
);
  localparam int NUM_LINES = 2 ** LOG2_NUM_LINES;
  localparam int LINE_B    = LINE_W / 8;
  localparam int OFF_W     = LOG2_WORDS_IN_LINE + 2;
  localparam int TAG_W     = ADDR_WIDTH - OFF_W;

  typedef enum logic [2:0] {IDLE, WB, REFILL, FLUSH_SCAN, FLUSH_WB} state_t;
  state_t state_q, state_d;

  logic [NUM_LINES-1:0]      valid_q;
  logic [TAG_W-1:0]          tag_q   [NUM_LINES];
  logic [LINE_W-1:0]         data_q  [NUM_LINES];
  logic [LINE_B-1:0]         dirty_q [NUM_LINES];
  logic [LOG2_NUM_LINES-1:0] ptr_q, victim_q, scan_q;
  logic [TAG_W-1:0]          miss_tag_q;
  logic                      refill_gnt_q;

  logic [TAG_W-1:0]              req_tag;
  logic [LOG2_WORDS_IN_LINE-1:0] req_word;
  logic                          hit, any_inv, refill_done;
  logic [LOG2_NUM_LINES-1:0]     hit_idx, inv_idx, victim, wb_idx;
  logic [LINE_W-1:0]             merged_line;
  logic [LINE_B-1:0]             merged_dirty;
  logic [31:0]                   hit_word;
  logic                          unused_addr;

  assign req_tag     = core_addr_i[ADDR_WIDTH-1:OFF_W];
  assign req_word    = core_addr_i[OFF_W-1:2];
  assign unused_addr = ^core_addr_i[1:0];
  assign wb_idx      = (state_q == FLUSH_WB) ? scan_q : victim_q;
  assign refill_done = (refill_gnt_q || mem_gnt_i) && mem_rvalid_i;

  // Descending loops so the lowest matching / lowest invalid index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    any_inv = 1'b0;
    inv_idx = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == req_tag) begin
        hit     = 1'b1;
        hit_idx = LOG2_NUM_LINES'(i);
      end
      if (!valid_q[i]) begin
        any_inv = 1'b1;
        inv_idx = LOG2_NUM_LINES'(i);
      end
    end
    victim = any_inv ? inv_idx : ptr_q;
  end

  always_comb begin
    merged_line  = data_q[hit_idx];
    merged_dirty = dirty_q[hit_idx];
    for (int b = 0; b < 4; b++) begin
      if (core_be_i[b]) begin
        merged_line[int'(req_word) * 32 + b * 8 +: 8] = core_wdata_i[b * 8 +: 8];
        merged_dirty[int'(req_word) * 4 + b]          = 1'b1;
      end
    end
    hit_word = data_q[hit_idx][int'(req_word) * 32 +: 32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    core_gnt_o   = 1'b0;
    flush_done_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = '0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    case (state_q)
      IDLE: begin
        if (flush_i) state_d = FLUSH_SCAN;
        else if (core_req_i) begin
          if (hit) core_gnt_o = 1'b1;
          else     state_d = (|dirty_q[victim]) ? WB : REFILL;
        end
      end
      WB, FLUSH_WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_be_o    = dirty_q[wb_idx];
        mem_addr_o  = {tag_q[wb_idx], {OFF_W{1'b0}}};
        mem_wdata_o = data_q[wb_idx];
        if (mem_gnt_i) state_d = (state_q == WB) ? REFILL : FLUSH_SCAN;
      end
      REFILL: begin
        mem_req_o  = !refill_gnt_q;
        mem_addr_o = {miss_tag_q, {OFF_W{1'b0}}};
        if (refill_done) state_d = IDLE;
      end
      FLUSH_SCAN: begin
        if (|dirty_q[scan_q]) state_d = FLUSH_WB;
        else if (scan_q == '1) begin
          flush_done_o = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      ptr_q         <= '0;
      victim_q      <= '0;
      scan_q        <= '0;
      miss_tag_q    <= '0;
      refill_gnt_q  <= 1'b0;
      core_rvalid_o <= 1'b0;
      core_rdata_o  <= '0;
      hit_cnt_o     <= '0;
      miss_cnt_o    <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
        dirty_q[i] <= '0;
      end
    end else begin
      core_rvalid_o <= 1'b0;
      core_rdata_o  <= '0;
      case (state_q)
        IDLE: begin
          if (flush_i) scan_q <= '0;
          else if (core_req_i) begin
            if (hit) begin
              core_rvalid_o <= 1'b1;
              if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 1'b1;
              if (core_we_i) begin
                data_q[hit_idx]  <= merged_line;
                dirty_q[hit_idx] <= merged_dirty;
              end else begin
                core_rdata_o <= hit_word;
              end
            end else begin
              if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
              victim_q   <= victim;
              miss_tag_q <= req_tag;
            end
          end
        end
        WB, FLUSH_WB: if (mem_gnt_i) dirty_q[wb_idx] <= '0;
        REFILL: begin
          if (mem_gnt_i) refill_gnt_q <= 1'b1;
          if (refill_done) begin
            refill_gnt_q      <= 1'b0;
            data_q[victim_q]  <= mem_rdata_i;
            tag_q[victim_q]   <= miss_tag_q;
            dirty_q[victim_q] <= '0;
            valid_q[victim_q] <= 1'b1;
            if (valid_q[victim_q]) ptr_q <= ptr_q + 1'b1;
          end
        end
        FLUSH_SCAN: if (!(|dirty_q[scan_q]) && scan_q != '1) scan_q <= scan_q + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_data_cache_l0_assoc.sv
// tb/tb_data_cache_l0_assoc.sv - self-checking bench for data_cache_l0_assoc
// Flat architectural memory plus a tag-list cache model predict load data, hit/miss counts and write-backs.
module tb_data_cache_l0_assoc;
  localparam int CW = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         core_req_i, core_we_i;
  logic [3:0]   core_be_i;
  logic [31:0]  core_addr_i, core_wdata_i;
  logic         core_gnt_o, core_rvalid_o;
  logic [31:0]  core_rdata_o;
  logic         flush_i, flush_done_o;
  logic         mem_req_o, mem_we_o;
  logic [15:0]  mem_be_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_gnt_i, mem_rvalid_i;
  logic [127:0] mem_rdata_i;
  logic [CW-1:0] hit_cnt_o, miss_cnt_o;

  data_cache_l0_assoc #(.ADDR_WIDTH(32), .LOG2_WORDS_IN_LINE(2), .LOG2_NUM_LINES(3), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
    .core_rdata_o(core_rdata_o), .flush_i(flush_i), .flush_done_o(flush_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] dram [4096];
  logic [7:0] refm [4096];

  int m_tag [8];
  bit m_val [8];
  int m_ptr, m_hits, m_miss;

  int gnt_dly = 0, rv_dly = 0;
  bit same_cyc = 0, resp_pause = 0;
  int wb_count = 0, rd_count = 0, unstable = 0;
  int wb_addr_log [$];
  logic [15:0] wb_be_log [$];
  int rd_addr_log [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rd_line(input logic [31:0] a);
    logic [127:0] l;
    for (int b = 0; b < 16; b++) l[b*8 +: 8] = dram[(int'(a[11:0]) & 32'hff0) + b];
    return l;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin m_val[i] = 0; m_tag[i] = 0; end
    m_ptr = 0; m_hits = 0; m_miss = 0;
    for (int i = 0; i < 4096; i++) refm[i] = dram[i];
  endfunction

  // A miss is counted once, then the refilled request is granted as a hit.
  function automatic void model_access(input int addr);
    int tag, v;
    tag = addr >> 4;
    for (int i = 0; i < 8; i++) if (m_val[i] && m_tag[i] == tag) begin m_hits++; return; end
    m_miss++; m_hits++;
    v = -1;
    for (int i = 7; i >= 0; i--) if (!m_val[i]) v = i;
    if (v < 0) begin v = m_ptr; m_ptr = (m_ptr + 1) % 8; end
    m_val[v] = 1; m_tag[v] = tag;
  endfunction

  initial begin
    logic s_we; logic [31:0] s_addr; logic [15:0] s_be; logic [127:0] s_wd;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      mem_gnt_i = 0; mem_rvalid_i = 0;
      if (mem_req_o === 1'b1 && !resp_pause) begin
        s_we = mem_we_o; s_addr = mem_addr_o; s_be = mem_be_o; s_wd = mem_wdata_o;
        for (int d = 0; d < gnt_dly; d++) begin
          @(negedge clk);
          if (mem_req_o !== 1'b1 || mem_we_o !== s_we || mem_addr_o !== s_addr ||
              mem_be_o !== s_be || mem_wdata_o !== s_wd) unstable++;
        end
        mem_gnt_i = 1;
        if (s_we) begin
          for (int b = 0; b < 16; b++) if (s_be[b]) dram[int'(s_addr[11:0]) + b] = s_wd[b*8 +: 8];
          wb_count++; wb_addr_log.push_back(int'(s_addr)); wb_be_log.push_back(s_be);
          @(negedge clk); mem_gnt_i = 0;
        end else begin
          rd_count++; rd_addr_log.push_back(int'(s_addr));
          if (same_cyc) begin
            mem_rvalid_i = 1; mem_rdata_i = rd_line(s_addr);
            @(negedge clk); mem_gnt_i = 0; mem_rvalid_i = 0;
          end else begin
            @(negedge clk); mem_gnt_i = 0;
            repeat (rv_dly) @(negedge clk);
            mem_rvalid_i = 1; mem_rdata_i = rd_line(s_addr);
            @(negedge clk); mem_rvalid_i = 0;
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 0; core_req_i = 0; core_we_i = 0; core_be_i = 0; core_addr_i = 0; core_wdata_i = 0; flush_i = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    model_reset();
    wb_count = 0; rd_count = 0;
    wb_addr_log.delete(); wb_be_log.delete(); rd_addr_log.delete();
  endtask

  task automatic access(input bit we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] exp;
    int a, n;
    a = int'(addr[11:0]) & 32'hffc;
    exp = {refm[a+3], refm[a+2], refm[a+1], refm[a]};
    if (we) for (int b = 0; b < 4; b++) if (be[b]) refm[a+b] = wd[b*8 +: 8];
    model_access(a);
    @(posedge clk); #1;
    core_req_i = 1; core_we_i = we; core_be_i = be; core_addr_i = addr; core_wdata_i = wd;
    n = 0;
    @(negedge clk);
    while (!core_gnt_o && n < 400) begin @(negedge clk); n++; end
    check("core_gnt", core_gnt_o, 1'b1);
    @(posedge clk); #1;
    core_req_i = 0;
    @(negedge clk);
    check("rvalid", core_rvalid_o, 1'b1);
    if (we) check("store_rdata", core_rdata_o, 32'h0);
    else    check("load_rdata", core_rdata_o, exp);
  endtask

  task automatic do_flush();
    int n;
    @(posedge clk); #1 flush_i = 1;
    @(posedge clk); #1 flush_i = 0;
    n = 0;
    @(negedge clk);
    while (!flush_done_o && n < 2000) begin @(negedge clk); n++; end
    check("flush_done", flush_done_o, 1'b1);
    @(negedge clk);
    check("flush_done_pulse", flush_done_o, 1'b0);
  endtask

  initial begin
    int n, bad;
    for (int i = 0; i < 4096; i++) dram[i] = 8'(i * 7 + 3);
    do_reset();
    rst_n = 0;
    #1;
    check("rst_gnt", core_gnt_o, 1'b0);
    check("rst_mem_req", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o}, '0);
    check("rst_rvalid", {core_rvalid_o, core_rdata_o, flush_done_o}, '0);
    check("rst_cnts", {hit_cnt_o, miss_cnt_o}, '0);
    do_reset();

    // Cold load, then partial store and reload
    access(0, 32'h100, 4'hf, 0);
    check("t1_wb_count", wb_count, 0);
    check("t1_rd_addr", rd_addr_log[0], 32'h100);
    access(1, 32'h104, 4'b0011, 32'hAABBCCDD);
    access(0, 32'h104, 4'hf, 0);
    check("t2_rd_count", rd_count, 1);
    check("t2_hits", hit_cnt_o, sat(m_hits));
    check("t2_miss", miss_cnt_o, sat(m_miss));

    // All lines dirty, then evict line 0 with a slow grant, then line 1
    do_reset();
    for (int i = 0; i < 8; i++) access(1, 32'(i * 16), 4'b0011, $urandom);
    wb_count = 0; wb_addr_log.delete(); wb_be_log.delete(); unstable = 0;
    gnt_dly = 5;
    access(0, 32'h200, 4'hf, 0);
    gnt_dly = 0;
    check("t3_wb_count", wb_count, 1);
    check("t3_wb_addr", wb_addr_log[0], 32'h000);
    check("t3_wb_be", wb_be_log[0], 16'h0003);
    check("t5_stable", unstable, 0);
    access(0, 32'h210, 4'hf, 0);
    check("t3_wb2_addr", wb_addr_log[1], 32'h010);
    check("t3_wb2_be", wb_be_log[1], 16'h0003);

    // Flush with lines 2 and 5 dirty
    do_reset();
    for (int i = 0; i < 8; i++) access(0, 32'(i * 16), 4'hf, 0);
    access(1, 32'h028, 4'b1000, 32'h11223344);
    access(1, 32'h054, 4'b0110, 32'h55667788);
    wb_count = 0; wb_addr_log.delete(); wb_be_log.delete();
    do_flush();
    check("t4_wb_count", wb_count, 2);
    check("t4_wb0_addr", wb_addr_log[0], 32'h020);
    check("t4_wb1_addr", wb_addr_log[1], 32'h050);
    check("t4_wb0_be", wb_be_log[0], 16'h0800);
    check("t4_wb1_be", wb_be_log[1], 16'h0060);
    wb_count = 0;
    do_flush();
    check("t4_reflush_wb", wb_count, 0);
    access(0, 32'h028, 4'hf, 0);
    check("t4_still_valid", miss_cnt_o, sat(m_miss));

    // Reset while a refill is outstanding
    do_reset();
    access(0, 32'h300, 4'hf, 0);
    resp_pause = 1;
    @(posedge clk); #1;
    core_req_i = 1; core_we_i = 0; core_be_i = 4'hf; core_addr_i = 32'h340;
    n = 0;
    @(negedge clk);
    while (!(mem_req_o && !mem_we_o) && n < 50) begin @(negedge clk); n++; end
    check("t5_in_refill", mem_req_o & ~mem_we_o, 1'b1);
    #2 rst_n = 0;
    #1;
    check("t5_rst_mem", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, '0);
    check("t5_rst_core", {core_gnt_o, core_rvalid_o, core_rdata_o, hit_cnt_o, miss_cnt_o}, '0);
    resp_pause = 0;
    do_reset();
    access(0, 32'h300, 4'hf, 0);
    check("t5_miss_after_rst", miss_cnt_o, 1);

    // Back-to-back hits saturate the hit counter
    @(posedge clk); #1;
    core_req_i = 1; core_we_i = 0; core_be_i = 4'hf; core_addr_i = 32'h304;
    repeat ((1 << CW) + 3) @(posedge clk);
    #1 core_req_i = 0;
    @(negedge clk);
    check("t6_hit_sat", hit_cnt_o, {CW{1'b1}});
    check("t6_miss", miss_cnt_o, 1);

    // Randomized traffic against the flat memory and tag model
    do_reset();
    unstable = 0;
    for (int k = 0; k < 120; k++) begin
      gnt_dly = $urandom_range(0, 3);
      rv_dly = $urandom_range(0, 3);
      same_cyc = 1'($urandom_range(0, 1));
      access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)), $urandom);
    end
    check("rnd_hits", hit_cnt_o, sat(m_hits));
    check("rnd_miss", miss_cnt_o, sat(m_miss));
    do_flush();
    bad = 0;
    for (int i = 0; i < 1024; i++) if (dram[i] !== refm[i]) bad++;
    check("rnd_dram_vs_ref", bad, 0);
    check("rnd_stable", unstable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
